// File: rtl/rgb_pl9823_pkg.sv
// rgb_pl9823_pkg: constants and types shared by the PL9823 pixel path
package rgb_pl9823_pkg;
    localparam int BITS_PER_LED = 24;
    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;
    // Line timing in 50 MHz CLK cycles, owned by the downstream encoder
    localparam int T0H_CYC   = 18;
    localparam int T1H_CYC   = 68;
    localparam int BIT_CYC   = 86;
    localparam int RESET_CYC = 2500;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/rgb_pl9823_bank_store.sv
// rgb_pl9823_bank_store: two pixel banks, back-bank write port and combinational front read port
module rgb_pl9823_bank_store
    import rgb_pl9823_pkg::*;
#(
    parameter int NUM_LEDS = 3,
    parameter int ADDR_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [BITS_PER_LED-1:0] wr_data,
    input  logic                    swap,
    input  logic [ADDR_W:0]         rd_idx,
    output logic [BITS_PER_LED-1:0] rd_data
);
    logic [BITS_PER_LED-1:0] mem_q [2][NUM_LEDS];
    logic [BITS_PER_LED-1:0] mem_d [2][NUM_LEDS];
    logic bank_sel_q, bank_sel_d;
    always_comb begin
        mem_d = mem_q;
        bank_sel_d = swap ? ~bank_sel_q : bank_sel_q;
        // Target is the pre-swap back bank, so a write in the swap cycle joins the published frame
        if (wr_en && int'(wr_addr) < NUM_LEDS) mem_d[~bank_sel_q][wr_addr] = wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            bank_sel_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            bank_sel_q <= bank_sel_d;
        end
    end
    assign rd_data = int'(rd_idx) < NUM_LEDS ? mem_q[bank_sel_q][rd_idx[ADDR_W-1:0]] : '0;
endmodule

// File: rtl/rgb_pl9823_frame_buf.sv
// rgb_pl9823_frame_buf: double-buffered frame store streaming MSB-first bits to the PL9823 encoder
module rgb_pl9823_frame_buf
    import rgb_pl9823_pkg::*;
#(
    parameter int NUM_LEDS = 3,
    parameter int ADDR_W   = 2,
    parameter int REPEAT   = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [23:0]       WR_DATA,
    input  logic              COMMIT,
    output logic              BIT_OUT,
    output logic              BIT_VALID,
    input  logic              BIT_READY,
    output logic              BIT_LAST,
    output logic              BUSY,
    output logic              PENDING
);
    state_t state_q, state_d;
    logic pending_q, pending_d;
    logic [BITS_PER_LED-1:0] shreg_q, shreg_d, pref_q, pref_d, rd_data;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0] pix_q, pix_d, rd_idx;
    logic swap, xfer, wrap, last;

    rgb_pl9823_bank_store #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W)) u_banks (
        .clk(CLK), .rst(RST), .wr_en(WR_EN), .wr_addr(WR_ADDR), .wr_data(WR_DATA),
        .swap(swap), .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            shreg_q   <= '0;
            pref_q    <= '0;
            bit_cnt_q <= '0;
            pix_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            shreg_q   <= shreg_d;
            pref_q    <= pref_d;
            bit_cnt_q <= bit_cnt_d;
            pix_q     <= pix_d;
        end
    end

    always_comb begin
        wrap = bit_cnt_q == 5'(BITS_PER_LED - 1);
        last = wrap && pix_q == (ADDR_W+1)'(NUM_LEDS);
        state_d = state_q == IDLE ? ((pending_q || REPEAT != 0) ? LOAD : IDLE)
                : state_q == LOAD ? SHIFT
                : (xfer && last) ? IDLE : SHIFT;
    end

    // Prefetch tracks front[pix] every shift cycle; the front bank is frozen, so it is ready long before the reload
    always_comb begin
        swap = state_q == IDLE && pending_q;
        pending_d = (pending_q && !swap) || COMMIT;
        rd_idx = state_q == LOAD ? '0 : pix_q;
        shreg_d = shreg_q;
        pref_d = pref_q;
        bit_cnt_d = bit_cnt_q;
        pix_d = pix_q;
        if (state_q == LOAD) begin
            shreg_d = rd_data;
            bit_cnt_d = '0;
            pix_d = (ADDR_W+1)'(1);
        end else if (state_q == SHIFT) begin
            pref_d = rd_data;
            if (xfer) begin
                shreg_d = wrap ? pref_q : {shreg_q[BITS_PER_LED-2:0], 1'b0};
                bit_cnt_d = wrap ? '0 : bit_cnt_q + 5'd1;
                pix_d = wrap ? pix_q + 1'b1 : pix_q;
            end
        end
    end

    always_comb begin
        BIT_VALID = state_q == SHIFT;
        BIT_OUT = BIT_VALID && shreg_q[BITS_PER_LED-1];
        BIT_LAST = BIT_VALID && last;
        BUSY = state_q != IDLE;
        PENDING = pending_q;
        xfer = BIT_VALID && BIT_READY;
    end
endmodule

// File: tb/tb_rgb_pl9823_frame_buf.sv
// tb_rgb_pl9823_frame_buf: vector table plus model-checked frames for the PL9823 frame buffer
module tb_rgb_pl9823_frame_buf;
    logic clk, rst, wr_en, commit, rdy, rdy_r;
    logic [1:0] wr_addr;
    logic [23:0] wr_data;
    logic bo, bv, bl, busy, pend;
    logic bo_r, bv_r, bl_r, busy_r, pend_r;
    int n_chk = 0;
    int n_fail = 0;
    logic [23:0] front_m [3];
    logic [23:0] back_m [3];
    bit pend_m;

    typedef struct {
        bit rst;
        bit wr;
        logic [1:0] addr;
        logic [23:0] data;
        bit cm;
        bit e_pend;
        bit e_busy;
        bit e_valid;
    } vec_t;
    vec_t tv [7];

    rgb_pl9823_frame_buf #(.NUM_LEDS(3), .ADDR_W(2), .REPEAT(0)) dut (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .COMMIT(commit),
        .BIT_OUT(bo), .BIT_VALID(bv), .BIT_READY(rdy), .BIT_LAST(bl), .BUSY(busy), .PENDING(pend)
    );
    rgb_pl9823_frame_buf #(.NUM_LEDS(3), .ADDR_W(2), .REPEAT(1)) dut_r (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .COMMIT(commit),
        .BIT_OUT(bo_r), .BIT_VALID(bv_r), .BIT_READY(rdy_r), .BIT_LAST(bl_r), .BUSY(busy_r), .PENDING(pend_r)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: whole-frame banks, swapped at the frame boundary that follows a commit
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            front_m[i] = '0;
            back_m[i] = '0;
        end
        pend_m = 0;
    endtask

    task automatic model_write(input logic [1:0] a, input logic [23:0] d);
        if (int'(a) < 3) back_m[a] = d;
    endtask

    task automatic boundary();
        logic [23:0] t [3];
        if (pend_m) begin
            t = front_m;
            front_m = back_m;
            back_m = t;
            pend_m = 0;
        end
    endtask

    task automatic pulse(input bit wr, input logic [1:0] a, input logic [23:0] d, input bit cm);
        wr_en = wr;
        wr_addr = a;
        wr_data = d;
        commit = cm;
        if (wr) model_write(a, d);
        if (cm) pend_m = 1;
        @(negedge clk);
        wr_en = 0;
        commit = 0;
    endtask

    task automatic get_frame(input bit r, input int mode, input int stop_at, input int mid_at,
                             input logic [1:0] ma, input logic [23:0] md,
                             output logic [71:0] bits, output bit last_ok, output int unst, output int span);
        int n = 0;
        int cyc = 0;
        int first = -1;
        bit pv = 0, pb = 0, px = 0, v, b, l, go, chk_pend = 0;
        bits = '0;
        last_ok = 1;
        unst = 0;
        span = 0;
        while (n < stop_at && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            wr_en = 0;
            commit = 0;
            v = r ? bv_r : bv;
            b = r ? bo_r : bo;
            l = r ? bl_r : bl;
            if (chk_pend) begin
                check("PENDING after mid-frame COMMIT", r ? pend_r : pend, 1);
                chk_pend = 0;
            end
            if (v && pv && !px && b != pb) unst++;
            go = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 86 == 0) : ($urandom_range(0, 3) != 0);
            if (r) rdy_r = go;
            else rdy = go;
            if (v && first < 0) first = cyc;
            if (v && go) begin
                bits[71-n] = b;
                if (l != (n == 71)) last_ok = 0;
                n++;
                if (n == 72) span = cyc - first + 1;
                if (n == mid_at) begin
                    wr_en = 1;
                    wr_addr = ma;
                    wr_data = md;
                    commit = 1;
                    model_write(ma, md);
                    pend_m = 1;
                    chk_pend = 1;
                end
            end
            pv = v;
            pb = b;
            px = v && go;
        end
        check("transfers before cycle limit", n, stop_at);
        @(negedge clk);
        wr_en = 0;
        commit = 0;
        rdy = 0;
        rdy_r = 0;
    endtask

    task automatic frame(input string nm, input bit r, input int mode, input int mid_at,
                         input logic [1:0] ma, input logic [23:0] md);
        logic [71:0] bits, exp;
        bit lok;
        int unst, span;
        exp = {front_m[0], front_m[1], front_m[2]};
        get_frame(r, mode, 72, mid_at, ma, md, bits, lok, unst, span);
        check({nm, " bit sequence"}, bits, exp);
        check({nm, " BIT_LAST on final transfer only"}, lok, 1);
        check({nm, " BIT_OUT stable while stalled"}, unst, 0);
        if (mode == 0) check({nm, " cycles for 72 bits"}, span, 72);
        if (!r) begin
            check({nm, " BIT_VALID after frame"}, bv, 0);
            check({nm, " BUSY after frame"}, busy, 0);
            check({nm, " PENDING after frame"}, pend, pend_m);
        end
    endtask

    initial begin
        logic [71:0] bits, exp;
        bit lok;
        int unst, span, cnt;
        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; commit = 0; rdy = 0; rdy_r = 0;
        model_reset();
        tv[0] = '{1'b1, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b1, 2'd3, 24'hAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b1, 2'd3, 24'h555555, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[6] = '{1'b0, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rst = tv[i].rst;
            wr_en = tv[i].wr;
            wr_addr = tv[i].addr;
            wr_data = tv[i].data;
            commit = tv[i].cm;
            if (tv[i].wr) model_write(tv[i].addr, tv[i].data);
            if (tv[i].cm) pend_m = 1;
            @(negedge clk);
            check($sformatf("vec%0d PENDING", i), pend, tv[i].e_pend);
            check($sformatf("vec%0d BUSY", i), busy, tv[i].e_busy);
            check($sformatf("vec%0d BIT_VALID", i), bv, tv[i].e_valid);
            check($sformatf("vec%0d BIT_LAST", i), bl, 0);
        end
        rst = 0; wr_en = 0; commit = 0;
        boundary();
        frame("out-of-range write frame", 0, 0, -1, 2'd0, 24'h0);

        pulse(1, 2'd0, 24'hFF0000, 0);
        pulse(1, 2'd1, 24'h00FF00, 0);
        pulse(1, 2'd2, 24'h0000FF, 0);
        pulse(0, 2'd0, 24'h0, 1);
        boundary();
        frame("rgb frame", 0, 0, -1, 2'd0, 24'h0);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bv || busy) cnt++;
        end
        check("idle without COMMIT", cnt, 0);

        pulse(1, 2'd0, 24'hFF0000, 0);
        pulse(1, 2'd1, 24'h00FF00, 0);
        pulse(1, 2'd2, 24'h0000FF, 0);
        pulse(0, 2'd0, 24'h0, 1);
        boundary();
        frame("slow-ready frame", 0, 1, -1, 2'd0, 24'h0);

        for (int i = 0; i < 3; i++) pulse(1, 2'(i), 24'($urandom), 0);
        pulse(0, 2'd0, 24'h0, 1);
        boundary();
        frame("frozen frame", 0, 2, 20, 2'd0, 24'h123456);
        boundary();
        frame("frame after mid commit", 0, 0, -1, 2'd0, 24'h0);

        for (int i = 0; i < 3; i++) pulse(1, 2'(i), 24'($urandom) | 24'h800000, 0);
        pulse(0, 2'd0, 24'h0, 1);
        boundary();
        exp = {front_m[0], front_m[1], front_m[2]};
        get_frame(0, 0, 30, 5, 2'd1, 24'($urandom), bits, lok, unst, span);
        check("first 30 bits before reset", bits[71:42], exp[71:42]);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        check("BIT_VALID after mid-frame reset", bv, 0);
        check("BUSY after mid-frame reset", busy, 0);
        check("PENDING after mid-frame reset", pend, 0);
        pulse(0, 2'd0, 24'h0, 1);
        boundary();
        frame("post-reset frame", 0, 0, -1, 2'd0, 24'h0);

        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) pulse(1, 2'(i), 24'($urandom), 0);
        pulse(0, 2'd0, 24'h0, 1);
        frame("repeat first frame", 1, 0, -1, 2'd0, 24'h0);
        boundary();
        frame("repeat committed frame", 1, 0, -1, 2'd0, 24'h0);
        boundary();
        frame("repeat again frame", 1, 2, 10, 2'd2, 24'($urandom));
        boundary();
        frame("repeat new data frame", 1, 0, -1, 2'd0, 24'h0);
        boundary();
        frame("repeat unchanged frame", 1, 0, -1, 2'd0, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
